// File: rtl/alu_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_if
//   Bundles every non-clock/reset signal of the shared-ALU sequencer:
//     - two request channels (reqN_*): valid/ready plus operands a, b,
//       op select, carry-in and signed-overflow mode
//     - two response channels (rspN_*): valid/ready plus captured result,
//       zero and overflow flags
//     - the ALU-facing bus (alu_*): operands/controls out, result/flags in
//     - busy status
//   modport slave  : the sequencer (alu_share_ctrl)
//   modport master : the environment (clients + ALU), e.g. a testbench
// ---------------------------------------------------------------------------
interface alu_share_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
);
  // request channel 0
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [SEL_W-1:0] req0_sel;
  logic             req0_cin;
  logic             req0_sign;
  // request channel 1
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [SEL_W-1:0] req1_sel;
  logic             req1_cin;
  logic             req1_sign;
  // response channel 0
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_out;
  logic             rsp0_zero;
  logic             rsp0_ovf;
  // response channel 1
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_out;
  logic             rsp1_zero;
  logic             rsp1_ovf;
  // ALU bus
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic             alu_cin;
  logic             alu_sign;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;
  logic             alu_ovf;
  // status
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, req0_cin, req0_sign,
    input  req1_valid, req1_a, req1_b, req1_sel, req1_cin, req1_sign,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_out, rsp0_zero, rsp0_ovf,
    output rsp1_valid, rsp1_out, rsp1_zero, rsp1_ovf,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_sel, alu_cin, alu_sign,
    input  alu_out, alu_zero, alu_ovf,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, req0_cin, req0_sign,
    output req1_valid, req1_a, req1_b, req1_sel, req1_cin, req1_sign,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_out, rsp0_zero, rsp0_ovf,
    input  rsp1_valid, rsp1_out, rsp1_zero, rsp1_ovf,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_sel, alu_cin, alu_sign,
    output alu_out, alu_zero, alu_ovf,
    input  busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
//   Round-robin arbiter and sequencer in front of a shared combinational ALU.
//   One operation is in flight at a time: IDLE (accept) -> EXEC (ALU driven
//   from operand registers) -> RESP (result held until the winner takes it).
// Ports
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : alu_share_ctrl_if.slave -- request/response channels, ALU bus, busy
// ---------------------------------------------------------------------------
module alu_share_ctrl #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input logic           clk,
  input logic           rst,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;

  // operand registers (drive the ALU permanently)
  logic [WIDTH-1:0] a_q, b_q;
  logic [SEL_W-1:0] sel_q;
  logic             cin_q, sign_q;
  // result registers (shared by both response channels)
  logic [WIDTH-1:0] out_q;
  logic             zero_q, ovf_q;
  // id of the operation in flight, and of the last one completed
  logic             id_q;
  logic             last_grant_q;

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic             grant_id;
  logic             accept;
  logic             rsp_done;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  // A lone requester wins; on a tie, the one not served last wins.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_q;
      default: grant_id = 1'b0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      IDLE: begin
        // rst gating keeps ready low while reset is held with a valid request
        if ((req_valid != 2'b00) && !rst) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready[id_q]) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      cin_q        <= 1'b0;
      sign_q       <= 1'b0;
      id_q         <= 1'b0;
      out_q        <= '0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (accept) begin
        a_q    <= grant_id ? bus.req1_a    : bus.req0_a;
        b_q    <= grant_id ? bus.req1_b    : bus.req0_b;
        sel_q  <= grant_id ? bus.req1_sel  : bus.req0_sel;
        cin_q  <= grant_id ? bus.req1_cin  : bus.req0_cin;
        sign_q <= grant_id ? bus.req1_sign : bus.req0_sign;
        id_q   <= grant_id;
      end
      // ALU is combinational: its result for the operand registers is
      // settled by the end of the single EXEC cycle.
      if (state_q == EXEC) begin
        out_q  <= bus.alu_out;
        zero_q <= bus.alu_zero;
        ovf_q  <= bus.alu_ovf;
      end
      if (rsp_done) begin
        last_grant_q <= id_q;
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept &  grant_id;

  // Only the valid bit is steered; both channels show the result registers.
  assign bus.rsp0_valid = (state_q == RESP) & ~id_q;
  assign bus.rsp1_valid = (state_q == RESP) &  id_q;
  assign bus.rsp0_out   = out_q;
  assign bus.rsp1_out   = out_q;
  assign bus.rsp0_zero  = zero_q;
  assign bus.rsp1_zero  = zero_q;
  assign bus.rsp0_ovf   = ovf_q;
  assign bus.rsp1_ovf   = ovf_q;

  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_sel  = sel_q;
  assign bus.alu_cin  = cin_q;
  assign bus.alu_sign = sign_q;

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
//   Directed bench for alu_share_ctrl. A small combinational ALU model sits
//   on the ALU bus; expected results are hand-computed constants.
//   ALU model op codes: 0 = a+b+cin, 1 = a-b, 0xF = (a==b), others = 0.
//   Overflow: signed overflow when sign=1, carry/borrow out when sign=0.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;

  localparam int WIDTH = 32;
  localparam int SEL_W = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic        cin;
    logic        sign;
    logic [31:0] eo;
    logic        ez;
    logic        eov;
  } op_t;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  alu_share_ctrl_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  alu_share_ctrl #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  logic [31:0] m_out;
  logic        m_ovf;
  logic [32:0] m_s;

  always_comb begin
    m_out = '0;
    m_ovf = 1'b0;
    m_s   = '0;
    case (bus.alu_sel)
      4'h0: begin
        m_s   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'd0, bus.alu_cin};
        m_out = m_s[31:0];
        m_ovf = bus.alu_sign ? ((bus.alu_a[31] == bus.alu_b[31]) && (m_out[31] != bus.alu_a[31]))
                             : m_s[32];
      end
      4'h1: begin
        m_s   = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        m_out = m_s[31:0];
        m_ovf = bus.alu_sign ? ((bus.alu_a[31] != bus.alu_b[31]) && (m_out[31] != bus.alu_a[31]))
                             : m_s[32];
      end
      4'hF: m_out = {31'd0, (bus.alu_a == bus.alu_b)};
      default: ;
    endcase
  end

  assign bus.alu_out  = m_out;
  assign bus.alu_zero = (m_out == 32'd0);
  assign bus.alu_ovf  = m_ovf;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive_op(input int ch, input logic v, input op_t o);
    if (ch == 0) begin
      bus.req0_valid = v; bus.req0_a = o.a; bus.req0_b = o.b;
      bus.req0_sel = o.sel; bus.req0_cin = o.cin; bus.req0_sign = o.sign;
    end else begin
      bus.req1_valid = v; bus.req1_a = o.a; bus.req1_b = o.b;
      bus.req1_sel = o.sel; bus.req1_cin = o.cin; bus.req1_sign = o.sign;
    end
  endtask

  task automatic set_rsp_ready(input int ch, input logic v);
    if (ch == 0) bus.rsp0_ready = v;
    else         bus.rsp1_ready = v;
  endtask

  function automatic logic req_ready(input int ch);
    return (ch == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rsp_valid(input int ch);
    return (ch == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [31:0] rsp_out(input int ch);
    return (ch == 0) ? bus.rsp0_out : bus.rsp1_out;
  endfunction

  function automatic logic rsp_zero(input int ch);
    return (ch == 0) ? bus.rsp0_zero : bus.rsp1_zero;
  endfunction

  function automatic logic rsp_ovf(input int ch);
    return (ch == 0) ? bus.rsp0_ovf : bus.rsp1_ovf;
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel,
                             input logic cin, input logic sign,
                             input logic [31:0] eo, input logic ez, input logic eov);
    op_t o;
    o.a = a; o.b = b; o.sel = sel; o.cin = cin; o.sign = sign;
    o.eo = eo; o.ez = ez; o.eov = eov;
    return o;
  endfunction

  task automatic chk_reset_vals(input string tag);
    check({tag, "_req0_ready"}, {31'd0, bus.req0_ready}, 32'd0);
    check({tag, "_req1_ready"}, {31'd0, bus.req1_ready}, 32'd0);
    check({tag, "_rsp0_valid"}, {31'd0, bus.rsp0_valid}, 32'd0);
    check({tag, "_rsp1_valid"}, {31'd0, bus.rsp1_valid}, 32'd0);
    check({tag, "_rsp0_out"}, bus.rsp0_out, 32'd0);
    check({tag, "_rsp1_out"}, bus.rsp1_out, 32'd0);
    check({tag, "_rsp_flags"}, {28'd0, bus.rsp0_zero, bus.rsp0_ovf, bus.rsp1_zero, bus.rsp1_ovf}, 32'd0);
    check({tag, "_alu_a"}, bus.alu_a, 32'd0);
    check({tag, "_alu_b"}, bus.alu_b, 32'd0);
    check({tag, "_alu_ctl"}, {26'd0, bus.alu_sel, bus.alu_cin, bus.alu_sign}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Full single operation on channel ch; entered and left at #1 after a posedge
  // with the DUT in IDLE. hold = cycles of response backpressure.
  task automatic run_op(input string tag, input int ch, input op_t o, input int hold);
    drive_op(ch, 1'b1, o);
    #1;
    check({tag, "_ready"}, {31'd0, req_ready(ch)}, 32'd1);
    check({tag, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    drive_op(ch, 1'b0, o);
    check({tag, "_busy_exec"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_ready_exec"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check({tag, "_alu_a"}, bus.alu_a, o.a);
    check({tag, "_alu_b"}, bus.alu_b, o.b);
    check({tag, "_alu_ctl"}, {26'd0, bus.alu_sel, bus.alu_cin, bus.alu_sign}, {26'd0, o.sel, o.cin, o.sign});
    check({tag, "_valid_exec"}, {31'd0, rsp_valid(ch)}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, rsp_valid(ch)}, 32'd1);
    check({tag, "_other_valid"}, {31'd0, rsp_valid(1 - ch)}, 32'd0);
    check({tag, "_out"}, rsp_out(ch), o.eo);
    check({tag, "_other_out"}, rsp_out(1 - ch), o.eo);
    check({tag, "_zero"}, {31'd0, rsp_zero(ch)}, {31'd0, o.ez});
    check({tag, "_ovf"}, {31'd0, rsp_ovf(ch)}, {31'd0, o.eov});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, {31'd0, rsp_valid(ch)}, 32'd1);
      check({tag, "_hold_out"}, rsp_out(ch), o.eo);
      check({tag, "_hold_flags"}, {30'd0, rsp_zero(ch), rsp_ovf(ch)}, {30'd0, o.ez, o.eov});
      check({tag, "_hold_other_ready"}, {31'd0, req_ready(1 - ch)}, 32'd0);
    end
    set_rsp_ready(ch, 1'b1);
    @(posedge clk); #1;
    set_rsp_ready(ch, 1'b0);
    check({tag, "_valid_done"}, {31'd0, rsp_valid(ch)}, 32'd0);
    check({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    $display("op %s ch=%0d sel=%h a=%h b=%h -> out=%h zero=%0b ovf=%0b",
             tag, ch, o.sel, o.a, o.b, rsp_out(ch), rsp_zero(ch), rsp_ovf(ch));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  op_t zero_op;
  op_t ops0[2];
  op_t ops1[2];
  op_t o;
  int  g;
  int  i0;
  int  i1;

  initial begin
    zero_op = mk(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive_op(0, 1'b0, zero_op);
    drive_op(1, 1'b0, zero_op);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // single add on req0
    run_op("add0", 0, mk(32'd5, 32'd7, 4'h0, 1'b1, 1'b0, 32'd13, 1'b0, 1'b0), 0);

    // signed overflow, then subtract to zero, on req1
    run_op("sovf1", 1, mk(32'h7FFF_FFFF, 32'd1, 4'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1), 0);
    run_op("sub1", 1, mk(32'd9, 32'd9, 4'h1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0), 0);

    // round-robin with both requesters continuously valid (last served: req1)
    ops0[0] = mk(32'd10, 32'd20, 4'h0, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0);
    ops0[1] = mk(32'd100, 32'd1, 4'h1, 1'b0, 1'b0, 32'd99, 1'b0, 1'b0);
    ops1[0] = mk(32'hFFFF_FFFF, 32'd1, 4'h0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    ops1[1] = mk(32'd3, 32'd5, 4'h1, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    i0 = 0;
    i1 = 0;
    drive_op(0, 1'b1, ops0[0]);
    drive_op(1, 1'b1, ops1[0]);
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      #1;
      check("rr_ready_win", {31'd0, req_ready(g)}, 32'd1);
      check("rr_ready_lose", {31'd0, req_ready(1 - g)}, 32'd0);
      o = (g == 0) ? ops0[i0] : ops1[i1];
      @(posedge clk); #1;
      if (g == 0) begin
        i0++;
        if (i0 < 2) drive_op(0, 1'b1, ops0[i0]);
        else        drive_op(0, 1'b0, zero_op);
      end else begin
        i1++;
        if (i1 < 2) drive_op(1, 1'b1, ops1[i1]);
        else        drive_op(1, 1'b0, zero_op);
      end
      check("rr_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
      check("rr_valid", {31'd0, rsp_valid(g)}, 32'd1);
      check("rr_other_valid", {31'd0, rsp_valid(1 - g)}, 32'd0);
      check("rr_out", rsp_out(g), o.eo);
      check("rr_flags", {30'd0, rsp_zero(g), rsp_ovf(g)}, {30'd0, o.ez, o.eov});
      check("rr_ready_resp", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
      set_rsp_ready(g, 1'b1);
      @(posedge clk); #1;
      set_rsp_ready(g, 1'b0);
      check("rr_valid_done", {31'd0, rsp_valid(g)}, 32'd0);
      $display("op rr%0d ch=%0d sel=%h a=%h b=%h -> out=%h", k, g, o.sel, o.a, o.b, rsp_out(g));
    end

    // backpressure on req0 while req1 waits (last served: req1, so req0 wins)
    drive_op(1, 1'b1, mk(32'd2, 32'd2, 4'h1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
    run_op("bp0", 0, mk(32'h1234_5678, 32'h1111_1111, 4'h0, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0), 10);
    check("bp_req1_ready_after", {31'd0, bus.req1_ready}, 32'd1);
    run_op("bp1", 1, mk(32'd2, 32'd2, 4'h1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0), 0);

    // make req0 the last served so the post-reset tie result is meaningful
    run_op("pre_rst", 0, mk(32'd1, 32'd1, 4'h0, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0), 0);

    // reset during EXEC
    drive_op(1, 1'b1, mk(32'd50, 32'd60, 4'h0, 1'b0, 1'b0, 32'd110, 1'b0, 1'b0));
    @(posedge clk); #1;
    drive_op(1, 1'b0, zero_op);
    check("rst_exec_busy_before", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_exec");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_exec_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    end

    // reset during RESP
    drive_op(1, 1'b1, mk(32'd7, 32'd8, 4'h0, 1'b0, 1'b0, 32'd15, 1'b0, 1'b0));
    @(posedge clk); #1;
    drive_op(1, 1'b0, zero_op);
    @(posedge clk); #1;
    check("rst_resp_valid_before", {31'd0, bus.rsp1_valid}, 32'd1);
    check("rst_resp_out_before", bus.rsp1_out, 32'd15);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rst_resp");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_resp_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    end

    // tie after reset goes to req0
    drive_op(0, 1'b1, mk(32'd1, 32'd2, 4'h0, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0));
    drive_op(1, 1'b1, mk(32'd8, 32'd3, 4'h1, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0));
    #1;
    check("tie_after_rst_req0", {31'd0, bus.req0_ready}, 32'd1);
    check("tie_after_rst_req1", {31'd0, bus.req1_ready}, 32'd0);
    @(posedge clk); #1;
    drive_op(0, 1'b0, zero_op);
    @(posedge clk); #1;
    check("tie_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
    check("tie_rsp0_out", bus.rsp0_out, 32'd3);
    bus.rsp0_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0;
    run_op("tie1", 1, mk(32'd8, 32'd3, 4'h1, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0), 0);

    // compare op and an unused op code
    run_op("cmp0", 0, mk(32'd3, 32'd3, 4'hF, 1'b0, 1'b0, 32'd1, 1'b0, 1'b0), 0);
    run_op("nop0", 0, mk(32'd3, 32'd3, 4'h3, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
